fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch PC controller: boot/run/flush/hold sequencing, predicted and redirected PC steering, pair-slot squash.
// Optional perf counters (redirects accepted, cycles in HOLD) when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic        zero_0_o,
    output logic        zero_1_o,
    output logic        flush_o,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] perf_redirect_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t      r_state, w_next_state;
    logic [31:0] r_pc, w_next_pc;
    logic [1:0]  r_flush_cnt, w_next_cnt;
    logic        r_zero1_frz;
    logic        w_stalled, w_active, w_zero1_live;
    logic [31:0] w_seq_pc;

    assign w_stalled    = stall_i | ~imem_ready_i;
    assign w_active     = reset_i & (r_state != BOOT);
    assign w_seq_pc     = {r_pc[31:3] + 29'd1, 3'b000};
    assign w_zero1_live = w_active & pred_taken_i & ~r_pc[2];

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_flush_cnt <= 2'd0;
            r_zero1_frz <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_flush_cnt <= w_next_cnt;
            if (r_state != HOLD)
                r_zero1_frz <= w_zero1_live;
        end
    end

    // A single-cycle flush is fully covered by the combinational redirect term, so skip FLUSH then.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT: w_next_state = RUN;
            default: begin
                if (redirect_i)
                    w_next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                else if (r_state == FLUSH && r_flush_cnt > 2'd1)
                    w_next_state = FLUSH;
                else if (w_stalled)
                    w_next_state = HOLD;
                else
                    w_next_state = RUN;
            end
        endcase
    end

    always_comb begin
        w_next_pc  = r_pc;
        w_next_cnt = r_flush_cnt;
        if (r_state != BOOT) begin
            if (redirect_i) begin
                w_next_pc  = redirect_pc_i;
                w_next_cnt = FLUSH_LOAD;
            end else begin
                if (r_flush_cnt != 2'd0)
                    w_next_cnt = r_flush_cnt - 2'd1;
                if (!w_stalled)
                    w_next_pc = pred_taken_i ? pred_target_i : w_seq_pc;
            end
        end
    end

    always_comb begin
        imem_req_o  = w_active;
        imem_addr_o = {r_pc[31:3], 3'b000};
        pc_o        = r_pc;
        zero_0_o    = r_pc[2];
        zero_1_o    = (r_state == HOLD) ? (reset_i & r_zero1_frz) : w_zero1_live;
        flush_o     = w_active & (redirect_i | (r_state == FLUSH));
        state_o     = r_state;
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_perf_redirect, r_perf_stall;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_perf_redirect <= 32'd0;
            r_perf_stall    <= 32'd0;
        end else begin
            if (redirect_i && r_state != BOOT)
                r_perf_redirect <= r_perf_redirect + 32'd1;
            if (r_state == HOLD)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_redirect_o = r_perf_redirect;
    assign perf_stall_o    = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: abstract PC/flush/hold model checked every cycle, plus hand-computed literal checks.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        rst, stall, redir, pt, rdy;
    logic [31:0] rpc, ptg;
    logic        req, z0, z1, flush;
    logic [31:0] addr, pc;
    logic [1:0]  st;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_r, perf_s;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Model: pc, whether in the boot cycle, remaining FLUSH-state cycles, stalled-last-cycle flag.
    logic [31:0] m_pc;
    logic        m_boot, m_hold, m_z1;
    int          m_rem;
    int unsigned m_nredir, m_nstall;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clock_i(clk), .reset_i(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(rpc), .pred_taken_i(pt), .pred_target_i(ptg),
        .imem_ready_i(rdy), .imem_req_o(req), .imem_addr_o(addr), .pc_o(pc),
        .zero_0_o(z0), .zero_1_o(z1), .flush_o(flush),
`ifdef FETCH_CTRL_PERF_EN
        .perf_redirect_o(perf_r), .perf_stall_o(perf_s),
`endif
        .state_o(st)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_boot)     return 2'd0;
        if (m_rem > 0)  return 2'd2;
        if (m_hold)     return 2'd3;
        return 2'd1;
    endfunction

    task automatic compare_model();
        logic live;
        live = pt & ~m_pc[2];
        chk("pc", pc, m_pc);
        chk("addr", addr, {m_pc[31:3], 3'b000});
        chk("req", {31'd0, req}, {31'd0, rst & ~m_boot});
        chk("flush", {31'd0, flush}, {31'd0, rst & ~m_boot & (redir | (m_rem > 0))});
        chk("zero0", {31'd0, z0}, {31'd0, m_pc[2]});
        chk("zero1", {31'd0, z1},
            {31'd0, rst & ~m_boot & ((m_state() == 2'd3) ? m_z1 : live)});
        chk("state", {30'd0, st}, {30'd0, m_state()});
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_redir", perf_r, m_nredir);
        chk("perf_stall", perf_s, m_nstall);
`endif
    endtask

    task automatic model_upd();
        logic stl;
        stl = stall | ~rdy;
        if (!rst) begin
            m_pc = RPC; m_boot = 1; m_rem = 0; m_hold = 0; m_z1 = 0;
            m_nredir = 0; m_nstall = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else begin
            if (m_state() != 2'd3) m_z1 = pt & ~m_pc[2];
            else                   m_nstall++;
            if (redir) begin
                m_pc = rpc; m_rem = FC - 1; m_hold = 0; m_nredir++;
            end else begin
                if (m_rem > 0) m_rem--;
                m_hold = stl;
                if (!stl) m_pc = pt ? ptg : ((m_pc & ~32'd7) + 32'd8);
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic y, input logic d,
                         input logic [31:0] dpc, input logic p, input logic [31:0] ppc);
        rst = r; stall = s; rdy = y; redir = d; rpc = dpc; pt = p; ptg = ppc;
        #1;
    endtask

    task automatic adv();
        if (chk_en) compare_model();
        @(posedge clk);
        model_upd();
        @(negedge clk);
    endtask

    // Quiet running inputs.
    task automatic run();
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0);
    endtask

    typedef struct {
        logic s, y, d, p;
        logic [31:0] dpc, ppc;
    } vec_t;

    initial begin
        vec_t tbl[12];
        tbl[0]  = '{0, 1, 0, 1, 32'h0,   32'h1004};
        tbl[1]  = '{0, 1, 0, 1, 32'h0,   32'h2000};
        tbl[2]  = '{1, 1, 0, 0, 32'h0,   32'h0};
        tbl[3]  = '{0, 0, 0, 1, 32'h0,   32'h3000};
        tbl[4]  = '{0, 1, 0, 0, 32'h0,   32'h0};
        tbl[5]  = '{0, 1, 1, 0, 32'h7C,  32'h0};
        tbl[6]  = '{1, 1, 0, 0, 32'h0,   32'h0};
        tbl[7]  = '{1, 1, 0, 1, 32'h0,   32'h900};
        tbl[8]  = '{0, 1, 0, 0, 32'h0,   32'h0};
        tbl[9]  = '{0, 1, 1, 1, 32'hA0,  32'hB0};
        tbl[10] = '{1, 0, 1, 0, 32'hC4,  32'h0};
        tbl[11] = '{0, 1, 0, 0, 32'h0,   32'h0};

        // Reset held for two edges.
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
        adv(); chk_en = 1;
        chk("rst_pc", pc, RPC);
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        adv();

        // Boot cycle, then sequential 0, 8, 0x10.
        run();
        chk("boot_req", {31'd0, req}, 32'd0);
        adv();
        chk("run_pc0", pc, 32'h0);
        chk("run_req", {31'd0, req}, 32'd1);
        adv(); chk("run_pc8", pc, 32'h8);
        adv(); chk("run_pc10", pc, 32'h10);
        adv(); adv();
        chk("pc20", pc, 32'h20);

        // Taken prediction in slot 0.
        drive(1, 0, 1, 0, 32'h0, 1, 32'h80);
        chk("pred_z1", {31'd0, z1}, 32'd1);
        adv(); run();
        chk("pred_pc", pc, 32'h80);

        // Redirect to a mid-pair target.
        drive(1, 0, 1, 1, 32'h104, 0, 32'h0);
        chk("redir_flushN", {31'd0, flush}, 32'd1);
        adv(); run();
        chk("redir_pc", pc, 32'h104);
        chk("redir_z0", {31'd0, z0}, 32'd1);
        chk("redir_flushN1", {31'd0, flush}, 32'd1);
        drive(1, 0, 1, 0, 32'h0, 1, 32'h900);
        chk("z1_odd", {31'd0, z1}, 32'd0);
        run();
        adv();
        chk("redir_flushN2", {31'd0, flush}, 32'd0);
        chk("redir_seq", pc, 32'h108);

        // Walk to 0x40 then stall three cycles, redirect out of HOLD.
        drive(1, 0, 1, 1, 32'h30, 0, 32'h0); adv();
        run(); adv(); adv();
        chk("pc40", pc, 32'h40);
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        adv(); adv(); adv();
        chk("hold_pc", pc, 32'h40);
        chk("hold_state", {30'd0, st}, 32'd3);
        drive(1, 1, 1, 1, 32'h200, 0, 32'h0);
        adv(); run();
        chk("hold_redir_pc", pc, 32'h200);
        adv(); adv();

        // Back-to-back redirects.
        drive(1, 0, 1, 1, 32'h300, 0, 32'h0);
        chk("b2b_flushN", {31'd0, flush}, 32'd1);
        adv();
        drive(1, 0, 1, 1, 32'h400, 0, 32'h0);
        chk("b2b_flushN1", {31'd0, flush}, 32'd1);
        adv(); run();
        chk("b2b_flushN2", {31'd0, flush}, 32'd1);
        chk("b2b_pc", pc, 32'h400);
        adv();
        chk("b2b_flushN3", {31'd0, flush}, 32'd0);

        // zero_1 frozen across HOLD; imem not ready also holds.
        drive(1, 1, 1, 0, 32'h0, 1, 32'h600);
        adv();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        chk("z1_frozen", {31'd0, z1}, 32'd1);
        chk("z1_hold_pc", pc, 32'h408);
        run(); adv();
        chk("unhold_pc", pc, 32'h410);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        adv();
        chk("notrdy_state", {30'd0, st}, 32'd3);
        chk("notrdy_pc", pc, 32'h410);
        run(); adv();

        // Address wrap and redirect-vs-prediction priority.
        drive(1, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0); adv();
        run();
        chk("wrap_pre", pc, 32'hFFFF_FFF8);
        adv();
        chk("wrap_post", pc, 32'h0);
        drive(1, 0, 1, 1, 32'h500, 1, 32'h900); adv();
        run();
        chk("redir_wins", pc, 32'h500);

        // Directed vector table under the model.
        foreach (tbl[i]) begin
            drive(1, tbl[i].s, tbl[i].y, tbl[i].d, tbl[i].dpc, tbl[i].p, tbl[i].ppc);
            adv();
        end

        // Reset in the middle of FLUSH.
        drive(1, 0, 1, 1, 32'h700, 0, 32'h0); adv();
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
        chk("rstf_flush_comb", {31'd0, flush}, 32'd0);
        adv();
        chk("rstf_state", {30'd0, st}, 32'd0);
        chk("rstf_pc", pc, RPC);
        run();
        chk("rstf_boot_flush", {31'd0, flush}, 32'd0);
        adv();
        chk("rstf_run_flush", {31'd0, flush}, 32'd0);
        chk("rstf_run_state", {30'd0, st}, 32'd1);

`ifdef FETCH_CTRL_PERF_EN
        // Two redirects and four stall cycles.
        drive(1, 0, 1, 1, 32'h100, 0, 32'h0); adv();
        drive(1, 0, 1, 1, 32'h200, 0, 32'h0); adv();
        run(); adv();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        adv(); adv(); adv(); adv();
        run(); adv();
        chk("perf_redir_lit", perf_r, 32'd2);
        chk("perf_stall_lit", perf_s, 32'd4);
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0); adv();
        chk("perf_redir_rst", perf_r, 32'd0);
        chk("perf_stall_rst", perf_s, 32'd0);
        run(); adv();
`endif
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
